// File: rtl/pairwise_match_pipe.sv
// Single-stage valid/ready pipeline computing the pairwise channel-equality matrix,
// the per-channel agreement counts, a unanimity flag and a saturating unanimous-sample count.
module pairwise_match_pipe #(
  parameter int unsigned N  = 5,
  parameter int unsigned W  = 1,
  parameter int unsigned CW = 8
) (
  input  logic                          clk,
  input  logic                          areset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N*W-1:0]                in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N*N-1:0]                out_match,
  output logic [N*$clog2(N)-1:0]        out_agree,
  output logic                          out_unanimous,
  output logic [CW-1:0]                 all_eq_cnt,
  input  logic                          clr
);

  localparam int unsigned AW   = $clog2(N);
  localparam int unsigned CNTW = AW + 1;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [N*N-1:0]  match_c;
  logic [N*AW-1:0] agree_c;
  logic [CNTW-1:0] row_cnt_c [N];
  logic            unanimous_c;
  logic            transfer_c;

  assign in_ready   = !out_valid || out_ready;
  assign transfer_c = in_valid && in_ready;

  // Row i, column j of the matrix sits at bit (N*N-1)-(i*N+j); channel 0 is the MSB slice.
  always_comb begin
    match_c = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        match_c[N*N-1-(i*N+j)] = (in_data[(N-i)*W-1 -: W] == in_data[(N-j)*W-1 -: W]);
      end
    end
  end

  // Row popcount needs one extra bit (it reaches N); the self-match is removed afterwards.
  always_comb begin
    agree_c = '0;
    for (int i = 0; i < N; i++) begin
      row_cnt_c[i] = '0;
      for (int j = 0; j < N; j++) begin
        row_cnt_c[i] = row_cnt_c[i] + CNTW'(match_c[N*N-1-(i*N+j)]);
      end
      agree_c[(N-i)*AW-1 -: AW] = AW'(row_cnt_c[i] - CNTW'(1));
    end
  end

  assign unanimous_c = &match_c;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      out_valid     <= 1'b0;
      out_match     <= '0;
      out_agree     <= '0;
      out_unanimous <= 1'b0;
    end else if (transfer_c) begin
      out_valid     <= 1'b1;
      out_match     <= match_c;
      out_agree     <= agree_c;
      out_unanimous <= unanimous_c;
    end else if (out_ready) begin
      out_valid     <= 1'b0;
    end
  end

  // Clear wins over a simultaneous unanimous transfer; the count sticks at its maximum.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      all_eq_cnt <= '0;
    end else if (clr) begin
      all_eq_cnt <= '0;
    end else if (transfer_c && unanimous_c && (all_eq_cnt != CNT_MAX)) begin
      all_eq_cnt <= all_eq_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_pairwise_match_pipe.sv
// Directed bench: three instances (N5/W1/CW8, N5/W1/CW2, N3/W4/CW8) sharing clock and reset.
module tb_pairwise_match_pipe;

  logic clk;
  logic areset_n;
  int   total;
  int   bad;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_unanimous, a_clr;
  logic [4:0]  a_in_data;
  logic [24:0] a_out_match;
  logic [14:0] a_out_agree;
  logic [7:0]  a_all_eq_cnt;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_unanimous, s_clr;
  logic [4:0]  s_in_data;
  logic [24:0] s_out_match;
  logic [14:0] s_out_agree;
  logic [1:0]  s_all_eq_cnt;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_unanimous, w_clr;
  logic [11:0] w_in_data;
  logic [8:0]  w_out_match;
  logic [5:0]  w_out_agree;
  logic [7:0]  w_all_eq_cnt;

  pairwise_match_pipe #(.N(5), .W(1), .CW(8)) u_a (
    .clk(clk), .areset_n(areset_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_match(a_out_match), .out_agree(a_out_agree), .out_unanimous(a_out_unanimous),
    .all_eq_cnt(a_all_eq_cnt), .clr(a_clr));

  pairwise_match_pipe #(.N(5), .W(1), .CW(2)) u_s (
    .clk(clk), .areset_n(areset_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_match(s_out_match), .out_agree(s_out_agree), .out_unanimous(s_out_unanimous),
    .all_eq_cnt(s_all_eq_cnt), .clr(s_clr));

  pairwise_match_pipe #(.N(3), .W(4), .CW(8)) u_w (
    .clk(clk), .areset_n(areset_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_data(w_in_data), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_match(w_out_match), .out_agree(w_out_agree), .out_unanimous(w_out_unanimous),
    .all_eq_cnt(w_all_eq_cnt), .clr(w_clr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    areset_n = 1'b0;
    a_in_valid = 0; a_out_ready = 0; a_clr = 0; a_in_data = '0;
    s_in_valid = 0; s_out_ready = 0; s_clr = 0; s_in_data = '0;
    w_in_valid = 0; w_out_ready = 0; w_clr = 0; w_in_data = '0;
    tick(); tick();
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", a_out_valid); end
    total++; if (a_out_match !== 25'h0) begin bad++; $display("FAIL reset_match got %h want 0", a_out_match); end
    total++; if (a_out_agree !== 15'h0) begin bad++; $display("FAIL reset_agree got %h want 0", a_out_agree); end
    total++; if (a_out_unanimous !== 1'b0) begin bad++; $display("FAIL reset_unan got %b want 0", a_out_unanimous); end
    total++; if (a_all_eq_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got %0d want 0", a_all_eq_cnt); end
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", a_in_ready); end
    @(negedge clk);
    areset_n = 1'b1;
  endtask

  task automatic test_basic();
    a_in_valid = 1; a_in_data = 5'b10110; a_out_ready = 1;
    tick();
    total++; if (a_out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got %b want 1", a_out_valid); end
    total++; if (a_out_match !== 25'h164DAC9) begin bad++; $display("FAIL basic_match got %h want 164dac9", a_out_match); end
    total++; if (a_out_agree !== {3'd2,3'd1,3'd2,3'd2,3'd1}) begin bad++; $display("FAIL basic_agree got %b want 010001010010001", a_out_agree); end
    total++; if (a_out_unanimous !== 1'b0) begin bad++; $display("FAIL basic_unan got %b want 0", a_out_unanimous); end
    total++; if (a_all_eq_cnt !== 8'd0) begin bad++; $display("FAIL basic_cnt got %0d want 0", a_all_eq_cnt); end
    a_in_valid = 0;
    tick();
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got %b want 0", a_out_valid); end
  endtask

  task automatic test_back_to_back();
    a_in_valid = 1; a_in_data = 5'b11111; a_out_ready = 1;
    tick();
    total++; if (a_out_match !== 25'h1FFFFFF) begin bad++; $display("FAIL b2b_match1 got %h want 1ffffff", a_out_match); end
    total++; if (a_out_agree !== {5{3'd4}}) begin bad++; $display("FAIL b2b_agree1 got %h want 4924", a_out_agree); end
    total++; if (a_out_unanimous !== 1'b1) begin bad++; $display("FAIL b2b_unan1 got %b want 1", a_out_unanimous); end
    total++; if (a_all_eq_cnt !== 8'd1) begin bad++; $display("FAIL b2b_cnt1 got %0d want 1", a_all_eq_cnt); end
    a_in_data = 5'b00000;
    tick();
    total++; if (a_out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid2 got %b want 1", a_out_valid); end
    total++; if (a_out_match !== 25'h1FFFFFF) begin bad++; $display("FAIL b2b_match2 got %h want 1ffffff", a_out_match); end
    total++; if (a_out_agree !== {5{3'd4}}) begin bad++; $display("FAIL b2b_agree2 got %h want 4924", a_out_agree); end
    total++; if (a_all_eq_cnt !== 8'd2) begin bad++; $display("FAIL b2b_cnt2 got %0d want 2", a_all_eq_cnt); end
    a_in_valid = 0;
    tick();
  endtask

  task automatic test_stall();
    a_in_valid = 1; a_in_data = 5'b10110; a_out_ready = 1;
    tick();
    a_in_data = 5'b11111; a_out_ready = 0;
    #1;
    for (int c = 0; c < 3; c++) begin
      total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d] got %b want 0", c, a_in_ready); end
      tick();
      total++; if (a_out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got %b want 1", c, a_out_valid); end
      total++; if (a_out_match !== 25'h164DAC9) begin bad++; $display("FAIL stall_match[%0d] got %h want 164dac9", c, a_out_match); end
      total++; if (a_all_eq_cnt !== 8'd2) begin bad++; $display("FAIL stall_cnt[%0d] got %0d want 2", c, a_all_eq_cnt); end
    end
    a_out_ready = 1;
    #1;
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready got %b want 1", a_in_ready); end
    tick();
    total++; if (a_out_match !== 25'h1FFFFFF) begin bad++; $display("FAIL stall_b_match got %h want 1ffffff", a_out_match); end
    total++; if (a_all_eq_cnt !== 8'd3) begin bad++; $display("FAIL stall_b_cnt got %0d want 3", a_all_eq_cnt); end
    a_in_valid = 0;
    tick();
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL stall_drain got %b want 0", a_out_valid); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    s_in_valid = 1; s_in_data = 5'b11111; s_out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++; if (s_all_eq_cnt !== exp_cnt[k]) begin bad++; $display("FAIL sat_cnt[%0d] got %0d want %0d", k, s_all_eq_cnt, exp_cnt[k]); end
    end
    s_clr = 1;
    tick();
    total++; if (s_all_eq_cnt !== 2'd0) begin bad++; $display("FAIL sat_clr got %0d want 0", s_all_eq_cnt); end
    total++; if (s_out_unanimous !== 1'b1) begin bad++; $display("FAIL sat_clr_unan got %b want 1", s_out_unanimous); end
    s_clr = 0; s_in_valid = 0;
    tick();
    total++; if (s_all_eq_cnt !== 2'd0) begin bad++; $display("FAIL sat_after_clr got %0d want 0", s_all_eq_cnt); end
  endtask

  task automatic test_width();
    w_in_valid = 1; w_out_ready = 1; w_in_data = {4'hA, 4'hA, 4'h5};
    tick();
    total++; if (w_out_match !== 9'b110_110_001) begin bad++; $display("FAIL w_aa5_match got %b want 110110001", w_out_match); end
    total++; if (w_out_agree !== {2'd1,2'd1,2'd0}) begin bad++; $display("FAIL w_aa5_agree got %b want 010100", w_out_agree); end
    total++; if (w_out_unanimous !== 1'b0) begin bad++; $display("FAIL w_aa5_unan got %b want 0", w_out_unanimous); end
    w_in_data = {4'h8, 4'h0, 4'h0};
    tick();
    total++; if (w_out_match !== 9'b100_011_011) begin bad++; $display("FAIL w_800_match got %b want 100011011", w_out_match); end
    total++; if (w_out_agree !== {2'd0,2'd1,2'd1}) begin bad++; $display("FAIL w_800_agree got %b want 000101", w_out_agree); end
    w_in_data = {4'h1, 4'h2, 4'h3};
    tick();
    total++; if (w_out_match !== 9'b100_010_001) begin bad++; $display("FAIL w_123_match got %b want 100010001", w_out_match); end
    total++; if (w_out_agree !== 6'b0) begin bad++; $display("FAIL w_123_agree got %b want 000000", w_out_agree); end
    w_in_data = {4'h3, 4'h3, 4'h3};
    tick();
    total++; if (w_out_match !== 9'h1FF) begin bad++; $display("FAIL w_333_match got %b want 111111111", w_out_match); end
    total++; if (w_out_agree !== {3{2'd2}}) begin bad++; $display("FAIL w_333_agree got %b want 101010", w_out_agree); end
    total++; if (w_out_unanimous !== 1'b1) begin bad++; $display("FAIL w_333_unan got %b want 1", w_out_unanimous); end
    total++; if (w_all_eq_cnt !== 8'd1) begin bad++; $display("FAIL w_333_cnt got %0d want 1", w_all_eq_cnt); end
    w_in_valid = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    a_clr = 1;
    tick();
    a_clr = 0;
    a_in_valid = 1; a_in_data = 5'b11111; a_out_ready = 1;
    tick(); tick();
    a_in_valid = 0; a_out_ready = 0;
    tick();
    total++; if (a_out_valid !== 1'b1 || a_all_eq_cnt !== 8'd2) begin bad++; $display("FAIL rmid_pre got valid=%b cnt=%0d want valid=1 cnt=2", a_out_valid, a_all_eq_cnt); end
    #2;
    areset_n = 1'b0;
    #1;
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got %b want 0", a_out_valid); end
    total++; if (a_out_match !== 25'h0 || a_out_agree !== 15'h0) begin bad++; $display("FAIL rmid_data got match=%h agree=%h want 0", a_out_match, a_out_agree); end
    total++; if (a_out_unanimous !== 1'b0 || a_all_eq_cnt !== 8'd0) begin bad++; $display("FAIL rmid_flags got unan=%b cnt=%0d want 0", a_out_unanimous, a_all_eq_cnt); end
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got %b want 1", a_in_ready); end
    @(negedge clk);
    areset_n = 1'b1;
    a_in_valid = 1; a_in_data = 5'b10110; a_out_ready = 1;
    tick();
    total++; if (a_out_valid !== 1'b1) begin bad++; $display("FAIL rmid_post_valid got %b want 1", a_out_valid); end
    total++; if (a_out_match !== 25'h164DAC9) begin bad++; $display("FAIL rmid_post_match got %h want 164dac9", a_out_match); end
    total++; if (a_all_eq_cnt !== 8'd0) begin bad++; $display("FAIL rmid_post_cnt got %0d want 0", a_all_eq_cnt); end
    a_in_valid = 0;
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_saturation();
    test_width();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
